// File: rtl/param_fwd_pipe.sv
// Parametrised 3-stage (ID/EX/WB) forwarding ALU pipeline with valid/ready issue and a 2-cycle multiplier.
// Optional RETIRE_CNT_EN macro adds a 32-bit register-file write counter on port retire_cnt.
module param_fwd_pipe #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int RW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3+3*RW-1:0] inst,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DW-1:0]     dbg_data
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    typedef enum logic {EX_IDLE, EX_MUL1} ex_state_t;

    logic [2:0]    w_op;
    logic [RW-1:0] w_rs1, w_rs2, w_rd;
    logic [2*RW-1:0] w_imm_raw;
    logic [DW-1:0] w_imm, w_src_a, w_src_b, w_ex_result;
    logic          w_accept, w_stall;

    logic [DW-1:0] r_regs [NREG];
    logic          r_sb_ex [NREG];
    logic          r_sb_wb [NREG];
    ex_state_t     r_state;
    logic          r_in_ready;
    logic          r_idex_wen;
    logic [2:0]    r_idex_op;
    logic [RW-1:0] r_idex_rd;
    logic [DW-1:0] r_idex_a, r_idex_b, r_mul_lo;
    logic          r_exwb_wen;
    logic [RW-1:0] r_exwb_rd;
    logic [DW-1:0] r_exwb_data;

    assign w_op      = inst[3+3*RW-1 -: 3];
    assign w_rs1     = inst[3*RW-1 -: RW];
    assign w_rs2     = inst[2*RW-1 -: RW];
    assign w_rd      = inst[RW-1:0];
    assign w_imm_raw = {w_rs1, w_rs2};
    assign w_accept  = in_valid & r_in_ready;
    assign w_stall   = (r_state == EX_MUL1);
    assign in_ready  = r_in_ready;
    assign dbg_data  = r_regs[dbg_sel];

    generate
        if (2*RW >= DW) begin : g_imm_trunc
            assign w_imm = w_imm_raw[DW-1:0];
        end else begin : g_imm_zext
            assign w_imm = {{(DW-2*RW){1'b0}}, w_imm_raw};
        end
    endgenerate

    // Youngest pending writer wins: EX beats WB beats the register file.
    always_comb begin
        if (r_sb_ex[w_rs1])      w_src_a = w_ex_result;
        else if (r_sb_wb[w_rs1]) w_src_a = r_exwb_data;
        else                     w_src_a = r_regs[w_rs1];
        if (r_sb_ex[w_rs2])      w_src_b = w_ex_result;
        else if (r_sb_wb[w_rs2]) w_src_b = r_exwb_data;
        else                     w_src_b = r_regs[w_rs2];
    end

    always_comb begin
        case (r_idex_op)
            OP_ADD:  w_ex_result = r_idex_a + r_idex_b;
            OP_SUB:  w_ex_result = r_idex_a - r_idex_b;
            OP_AND:  w_ex_result = r_idex_a & r_idex_b;
            OP_OR:   w_ex_result = r_idex_a | r_idex_b;
            OP_XOR:  w_ex_result = r_idex_a ^ r_idex_b;
            OP_MUL:  w_ex_result = r_mul_lo;
            OP_LDI:  w_ex_result = r_idex_a;
            default: w_ex_result = '0;
        endcase
    end

    // EX FSM: a MUL spends one cycle in EX_MUL1 forming the product while issue is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EX_IDLE;
            r_in_ready <= 1'b1;
            r_mul_lo   <= '0;
        end else begin
            case (r_state)
                EX_IDLE: begin
                    if (w_accept && w_op == OP_MUL) begin
                        r_state    <= EX_MUL1;
                        r_in_ready <= 1'b0;
                    end
                end
                EX_MUL1: begin
                    r_state    <= EX_IDLE;
                    r_in_ready <= 1'b1;
                    r_mul_lo   <= r_idex_a * r_idex_b;
                end
                default: begin
                    r_state    <= EX_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex_wen <= 1'b0;
            r_idex_op  <= OP_NOP;
            r_idex_rd  <= '0;
            r_idex_a   <= '0;
            r_idex_b   <= '0;
        end else if (!w_stall) begin
            r_idex_wen <= w_accept && (w_op != OP_NOP);
            r_idex_op  <= w_accept ? w_op : OP_NOP;
            r_idex_rd  <= w_rd;
            r_idex_a   <= (w_op == OP_LDI) ? w_imm : w_src_a;
            r_idex_b   <= w_src_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exwb_wen  <= 1'b0;
            r_exwb_rd   <= '0;
            r_exwb_data <= '0;
        end else if (w_stall) begin
            r_exwb_wen  <= 1'b0;
        end else begin
            r_exwb_wen  <= r_idex_wen;
            r_exwb_rd   <= r_idex_rd;
            r_exwb_data <= w_ex_result;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_regs[gi] <= '0;
                else if (r_exwb_wen && r_exwb_rd == RW'(gi))
                    r_regs[gi] <= r_exwb_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sb_ex[gi] <= 1'b0;
                    r_sb_wb[gi] <= 1'b0;
                end else if (w_stall) begin
                    r_sb_wb[gi] <= 1'b0;
                end else begin
                    r_sb_wb[gi] <= r_sb_ex[gi];
                    r_sb_ex[gi] <= w_accept && (w_op != OP_NOP) && (w_rd == RW'(gi));
                end
            end
        end
    endgenerate

`ifdef RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retire_cnt <= '0;
        else if (r_exwb_wen)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule
